// File: rtl/pmem_arbiter.sv
// Physical-memory arbiter between the I-cache and D-cache line miss paths.
// Fixed D-over-I priority with an I-side starvation counter; define
// ARB_ROUND_ROBIN_EN to replace the counter with round-robin arbitration.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ic_pmem_*           I-cache line read request / response
//   dc_pmem_*           D-cache line read/writeback request / response
//   dc_byte_enable      D-cache per-byte write enable
//   mem_*               single physical-memory port (read/write/addr/data/resp)
module pmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ic_pmem_read,
    input  logic [31:0]  ic_pmem_address,
    output logic [255:0] ic_pmem_rdata,
    output logic         ic_pmem_resp,
    input  logic         dc_pmem_read,
    input  logic         dc_pmem_write,
    input  logic [31:0]  dc_pmem_address,
    input  logic [255:0] dc_pmem_wdata,
    input  logic [31:0]  dc_byte_enable,
    output logic [255:0] dc_pmem_rdata,
    output logic         dc_pmem_resp,
    output logic         mem_read,
    output logic         mem_write,
    output logic [31:0]  mem_address,
    output logic [255:0] mem_wdata,
    output logic [31:0]  mem_byte_enable,
    input  logic [255:0] mem_rdata,
    input  logic         mem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_cnt_nx;
    // 1 = D-side received the most recent grant
    logic             last_grant;
    logic             last_grant_nx;
    logic             dc_req;
    logic             grant_i;
    logic             grant_d;

    assign dc_req = dc_pmem_read | dc_pmem_write;

    // Read data is broadcast; only the resp strobe qualifies it.
    assign ic_pmem_rdata = mem_rdata;
    assign dc_pmem_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nx;
            starve_cnt <= starve_cnt_nx;
            last_grant <= last_grant_nx;
        end
    end

    // Grant decision, only meaningful while idle.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            if (ic_pmem_read && dc_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                grant_i = last_grant;
                grant_d = !last_grant;
`else
                grant_i = (starve_cnt == LIMIT);
                grant_d = (starve_cnt != LIMIT);
`endif
            end else begin
                grant_i = ic_pmem_read;
                grant_d = dc_req;
            end
        end
    end

    always_comb begin
        state_nx      = state;
        starve_cnt_nx = starve_cnt;
        last_grant_nx = last_grant;
        unique case (state)
            IDLE: begin
                if (grant_i)
                    state_nx = SERVE_I;
                else if (grant_d)
                    state_nx = SERVE_D;
            end
            SERVE_I: if (mem_resp) state_nx = IDLE;
            SERVE_D: if (mem_resp) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        if (grant_i)
            last_grant_nx = 1'b0;
        else if (grant_d)
            last_grant_nx = 1'b1;

`ifdef ARB_ROUND_ROBIN_EN
        starve_cnt_nx = '0;
`else
        // Count D wins that left I waiting; saturate at the limit.
        if (grant_i)
            starve_cnt_nx = '0;
        else if (grant_d && ic_pmem_read && starve_cnt != LIMIT)
            starve_cnt_nx = starve_cnt + 1'b1;
`endif
    end

    always_comb begin
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_wdata       = '0;
        mem_byte_enable = '0;
        ic_pmem_resp    = 1'b0;
        dc_pmem_resp    = 1'b0;
        unique case (state)
            SERVE_I: begin
                mem_read        = ic_pmem_read;
                mem_address     = ic_pmem_address;
                mem_byte_enable = 32'hFFFF_FFFF;
                ic_pmem_resp    = mem_resp;
            end
            SERVE_D: begin
                // A simultaneous read+write forwards only the write.
                mem_read        = dc_pmem_read & ~dc_pmem_write;
                mem_write       = dc_pmem_write;
                mem_address     = dc_pmem_address;
                mem_wdata       = dc_pmem_wdata;
                mem_byte_enable = dc_byte_enable;
                dc_pmem_resp    = mem_resp;
            end
            default: ;
        endcase
    end

    a_dc_rw_excl: assert property (@(posedge clk) disable iff (rst)
        !(dc_pmem_read && dc_pmem_write));

    a_ic_hold: assert property (@(posedge clk) disable iff (rst)
        (state == SERVE_I) |-> ic_pmem_read);

    a_dc_hold: assert property (@(posedge clk) disable iff (rst)
        (state == SERVE_D) |-> dc_req);

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed-vector bench for pmem_arbiter (default fixed-priority build).
// Inputs change on negedge; outputs are observed mid-cycle.
module tb_pmem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         ic_pmem_read;
    logic [31:0]  ic_pmem_address;
    logic [255:0] ic_pmem_rdata;
    logic         ic_pmem_resp;
    logic         dc_pmem_read;
    logic         dc_pmem_write;
    logic [31:0]  dc_pmem_address;
    logic [255:0] dc_pmem_wdata;
    logic [31:0]  dc_byte_enable;
    logic [255:0] dc_pmem_rdata;
    logic         dc_pmem_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata;
    logic [31:0]  mem_byte_enable;
    logic [255:0] mem_rdata;
    logic         mem_resp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pmem_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .ic_pmem_read    (ic_pmem_read),
        .ic_pmem_address (ic_pmem_address),
        .ic_pmem_rdata   (ic_pmem_rdata),
        .ic_pmem_resp    (ic_pmem_resp),
        .dc_pmem_read    (dc_pmem_read),
        .dc_pmem_write   (dc_pmem_write),
        .dc_pmem_address (dc_pmem_address),
        .dc_pmem_wdata   (dc_pmem_wdata),
        .dc_byte_enable  (dc_byte_enable),
        .dc_pmem_rdata   (dc_pmem_rdata),
        .dc_pmem_resp    (dc_pmem_resp),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp)
    );

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    localparam logic [255:0] RD_X = {8{32'hA5A5_0001}};
    localparam logic [255:0] RD_Y = {8{32'h5A5A_0002}};
    localparam logic [255:0] WD_W = {8{32'hC0DE_0003}};

    initial begin
        rst             = 1'b1;
        ic_pmem_read    = 1'b0;
        ic_pmem_address = '0;
        dc_pmem_read    = 1'b0;
        dc_pmem_write   = 1'b0;
        dc_pmem_address = '0;
        dc_pmem_wdata   = '0;
        dc_byte_enable  = '0;
        mem_rdata       = '0;
        mem_resp        = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_mem_read", 256'(mem_read), 256'(0));
        check("rst_mem_write", 256'(mem_write), 256'(0));
        check("rst_mem_addr", 256'(mem_address), 256'(0));
        check("rst_mem_wdata", mem_wdata, 256'(0));
        check("rst_mem_be", 256'(mem_byte_enable), 256'(0));
        check("rst_resps", 256'({ic_pmem_resp, dc_pmem_resp}), 256'(0));
        rst = 1'b0;
        @(negedge clk);

        // I read alone
        ic_pmem_read    = 1'b1;
        ic_pmem_address = 32'h0000_0040;
        #1 check("i_lat0_read", 256'(mem_read), 256'(0));
        @(negedge clk);
        check("i_mem_read", 256'(mem_read), 256'(1));
        check("i_mem_addr", 256'(mem_address), 256'(32'h40));
        check("i_mem_be", 256'(mem_byte_enable), 256'(32'hFFFF_FFFF));
        check("i_mem_write", 256'(mem_write), 256'(0));
        mem_rdata = RD_X;
        mem_resp  = 1'b1;
        #1 check("i_resp", 256'(ic_pmem_resp), 256'(1));
        check("i_rdata", ic_pmem_rdata, RD_X);
        check("i_dc_resp", 256'(dc_pmem_resp), 256'(0));
        @(negedge clk);
        mem_resp     = 1'b0;
        ic_pmem_read = 1'b0;
        #1 check("i_done_idle", 256'(mem_read), 256'(0));

        // mem_resp while idle is ignored
        mem_resp = 1'b1;
        #1 check("idle_resp", 256'({ic_pmem_resp, dc_pmem_resp}), 256'(0));
        @(negedge clk);
        mem_resp = 1'b0;

        // D write with partial byte enable
        dc_pmem_write   = 1'b1;
        dc_pmem_address = 32'h0000_1000;
        dc_pmem_wdata   = WD_W;
        dc_byte_enable  = 32'h0000_000F;
        @(negedge clk);
        check("d_mem_write", 256'(mem_write), 256'(1));
        check("d_mem_read", 256'(mem_read), 256'(0));
        check("d_mem_addr", 256'(mem_address), 256'(32'h1000));
        check("d_mem_be", 256'(mem_byte_enable), 256'(32'hF));
        check("d_mem_wdata", mem_wdata, WD_W);
        mem_resp = 1'b1;
        #1 check("d_resp", 256'(dc_pmem_resp), 256'(1));
        check("d_ic_resp", 256'(ic_pmem_resp), 256'(0));
        @(negedge clk);
        mem_resp       = 1'b0;
        dc_pmem_write  = 1'b0;
        dc_byte_enable = '0;
        dc_pmem_wdata  = '0;
        @(negedge clk);

        // Simultaneous requests: D first, then I
        ic_pmem_read    = 1'b1;
        ic_pmem_address = 32'h0000_0080;
        dc_pmem_read    = 1'b1;
        dc_pmem_address = 32'h0000_2000;
        @(negedge clk);
        check("both_d_addr", 256'(mem_address), 256'(32'h2000));
        check("both_d_read", 256'(mem_read), 256'(1));
        mem_rdata = RD_Y;
        mem_resp  = 1'b1;
        #1 check("both_d_resp", 256'(dc_pmem_resp), 256'(1));
        check("both_d_rdata", dc_pmem_rdata, RD_Y);
        check("both_i_wait", 256'(ic_pmem_resp), 256'(0));
        @(negedge clk);
        mem_resp     = 1'b0;
        dc_pmem_read = 1'b0;
        #1 check("both_idle_gap", 256'(mem_read), 256'(0));
        @(negedge clk);
        check("both_i_addr", 256'(mem_address), 256'(32'h80));
        check("both_i_read", 256'(mem_read), 256'(1));
        mem_resp = 1'b1;
        #1 check("both_i_resp", 256'(ic_pmem_resp), 256'(1));
        @(negedge clk);
        mem_resp     = 1'b0;
        ic_pmem_read = 1'b0;

        // Starvation: D continuous, I pending -> D x4, I, then D again
        do_reset();
        ic_pmem_read    = 1'b1;
        ic_pmem_address = 32'h0000_0100;
        dc_pmem_read    = 1'b1;
        dc_pmem_address = 32'h0000_3000;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("starve_g%0d", k), 256'(mem_address),
                  (k == 4) ? 256'(32'h100) : 256'(32'h3000));
            mem_resp = 1'b1;
            @(negedge clk);
            mem_resp = 1'b0;
        end
        ic_pmem_read = 1'b0;
        dc_pmem_read = 1'b0;
        @(negedge clk);

        // Reset during SERVE_D before mem_resp
        dc_pmem_write   = 1'b1;
        dc_pmem_address = 32'h0000_4000;
        dc_byte_enable  = 32'hFFFF_FFFF;
        @(negedge clk);
        check("rst_mid_pre_write", 256'(mem_write), 256'(1));
        rst           = 1'b1;
        dc_pmem_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_write", 256'(mem_write), 256'(0));
        check("rst_mid_addr", 256'(mem_address), 256'(0));
        mem_resp = 1'b1;
        #1 check("rst_mid_late_resp", 256'(dc_pmem_resp), 256'(0));
        @(negedge clk);
        mem_resp = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
